// File: rtl/mips_instr_rom_loader_pkg.sv
// rtl/mips_instr_rom_loader_pkg.sv - shared MIPS memory-model types, constants and helpers
package mips_tb_pkg;

  typedef logic [31:0] instr_word_t;

  localparam instr_word_t MIPS_RESET_VECTOR = 32'hBFC00000;
  localparam instr_word_t MIPS_NOP          = 32'h00000000;

  function automatic instr_word_t byte_swap32(input instr_word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_byte_swap.sv
// rtl/mips_byte_swap.sv - 32-bit byte-lane reversal, shared by instruction and data memory models
module mips_byte_swap
  import mips_tb_pkg::*;
(
  input  instr_word_t data_in,
  output instr_word_t data_out
);

  assign data_out = byte_swap32(data_in);

endmodule

// File: rtl/mips_instr_rom_loader.sv
// rtl/mips_instr_rom_loader.sv - serially preloaded instruction memory with address decode and fault capture
module mips_instr_rom_loader
  import mips_tb_pkg::*;
#(
  parameter int          DEPTH        = 64,
  parameter logic [31:0] BASE_ADDR    = MIPS_RESET_VECTOR,
  parameter bit          SWAP_BYTES   = 1'b1,
  parameter int          READ_LATENCY = 0,
  parameter instr_word_t FILL_WORD    = MIPS_NOP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     load_clear,
  input  logic                     load_valid,
  input  logic [31:0]              load_data,
  output logic                     load_ready,
  output logic [$clog2(DEPTH):0]   loaded_words,
  input  logic [31:0]              instr_address,
  output logic [31:0]              instr_readdata,
  output logic                     instr_valid,
  output logic                     fault,
  output logic [31:0]              fault_address
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  instr_word_t   mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_we;
  logic          fault_q, fault_d;
  logic [31:0]   fault_addr_q, fault_addr_d;

  logic [31:0]   off;
  logic          aligned, in_array, is_loaded, hit, fault_cond;
  instr_word_t   raw_word, swapped_word, data_c;

  // Loader: clear wins over a write; the count doubles as the write pointer.
  always_comb begin
    cnt_d  = cnt_q;
    mem_we = 1'b0;
    if (load_clear) begin
      cnt_d = '0;
    end else if (load_valid && load_ready) begin
      mem_we = 1'b1;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cnt_q[AW-1:0]] <= load_data;
  end

  assign load_ready   = ~cnt_q[AW];
  assign loaded_words = cnt_q;

  // Addresses below the base wrap to a huge offset and miss the array.
  assign off        = instr_address - BASE_ADDR;
  assign aligned    = (off[1:0] == 2'b00);
  assign in_array   = (off < 32'(4 * DEPTH));
  assign is_loaded  = ({1'b0, off[AW+1:2]} < cnt_q);
  assign hit        = aligned && in_array && is_loaded;
  assign fault_cond = (instr_address != 32'h0) && !(aligned && in_array);

  assign raw_word = mem_q[off[AW+1:2]];

  mips_byte_swap u_swap (
    .data_in  (raw_word),
    .data_out (swapped_word)
  );

  assign data_c = hit ? (SWAP_BYTES ? swapped_word : raw_word) : FILL_WORD;

  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (clk_enable && fault_cond && !fault_q) begin
      fault_d      = 1'b1;
      fault_addr_d = instr_address;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault         = fault_q;
  assign fault_address = fault_addr_q;

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign instr_readdata = data_c;
      assign instr_valid    = 1'b1;
    end else begin : g_reg_read
      instr_word_t rdata_q, rdata_d;
      logic        valid_q, valid_d;

      always_comb begin
        rdata_d = rdata_q;
        valid_d = valid_q;
        if (clk_enable) begin
          rdata_d = data_c;
          valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_q <= FILL_WORD;
          valid_q <= 1'b0;
        end else begin
          rdata_q <= rdata_d;
          valid_q <= valid_d;
        end
      end

      assign instr_readdata = rdata_q;
      assign instr_valid    = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_mips_instr_rom_loader.sv
// tb/tb_mips_instr_rom_loader.sv - directed self-checking bench for mips_instr_rom_loader
module tb_mips_instr_rom_loader;

  logic        clk;
  logic        reset;
  logic        ce   [3];
  logic        lc   [3];
  logic        lv   [3];
  logic [31:0] ld   [3];
  logic [31:0] addr [3];
  logic        rdy  [3];
  logic [31:0] rd   [3];
  logic        vld  [3];
  logic        flt  [3];
  logic [31:0] fa   [3];
  logic [6:0]  lw_a, lw_c;
  logic [2:0]  lw_b;

  int vectors = 0;
  int miscompares = 0;

  // a: 64 words, swapped, combinational read
  mips_instr_rom_loader #(.DEPTH(64), .SWAP_BYTES(1'b1), .READ_LATENCY(0)) u_a (
    .clk(clk), .reset(reset), .clk_enable(ce[0]), .load_clear(lc[0]), .load_valid(lv[0]),
    .load_data(ld[0]), .load_ready(rdy[0]), .loaded_words(lw_a), .instr_address(addr[0]),
    .instr_readdata(rd[0]), .instr_valid(vld[0]), .fault(flt[0]), .fault_address(fa[0]));

  // b: 4 words, unswapped, distinct fill word
  mips_instr_rom_loader #(.DEPTH(4), .SWAP_BYTES(1'b0), .READ_LATENCY(0), .FILL_WORD(32'hDEADBEEF)) u_b (
    .clk(clk), .reset(reset), .clk_enable(ce[1]), .load_clear(lc[1]), .load_valid(lv[1]),
    .load_data(ld[1]), .load_ready(rdy[1]), .loaded_words(lw_b), .instr_address(addr[1]),
    .instr_readdata(rd[1]), .instr_valid(vld[1]), .fault(flt[1]), .fault_address(fa[1]));

  // c: 64 words, swapped, registered read
  mips_instr_rom_loader #(.DEPTH(64), .SWAP_BYTES(1'b1), .READ_LATENCY(1)) u_c (
    .clk(clk), .reset(reset), .clk_enable(ce[2]), .load_clear(lc[2]), .load_valid(lv[2]),
    .load_data(ld[2]), .load_ready(rdy[2]), .loaded_words(lw_c), .instr_address(addr[2]),
    .instr_readdata(rd[2]), .instr_valid(vld[2]), .fault(flt[2]), .fault_address(fa[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [31:0] d);
    lv[i] = 1'b1;
    ld[i] = d;
    tick();
    lv[i] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ce[i] = 1'b0; lc[i] = 1'b0; lv[i] = 1'b0; ld[i] = 32'h0; addr[i] = 32'h0;
    end
    tick();
    tick();

    chk("rst_a_loaded", 32'(lw_a), 32'd0);
    chk("rst_a_ready", 32'(rdy[0]), 32'd1);
    chk("rst_a_fault", 32'(flt[0]), 32'd0);
    chk("rst_a_faddr", fa[0], 32'h0);
    chk("rst_a_valid", 32'(vld[0]), 32'd1);
    chk("rst_c_valid", 32'(vld[2]), 32'd0);
    chk("rst_c_rdata", rd[2], 32'h0);

    reset = 1'b0;
    ce[0] = 1'b1;

    // program load and swapped fetch
    load(0, 32'h24846006);
    load(0, 32'h00A41006);
    load(0, 32'h00000008);
    addr[0] = 32'hBFC0000C;
    lv[0] = 1'b1;
    ld[0] = 32'h24000000;
    #1;
    chk("a_rdw_old", rd[0], 32'h00000000);
    tick();
    lv[0] = 1'b0;
    chk("a_rdw_new", rd[0], 32'h00000024);
    chk("a_loaded4", 32'(lw_a), 32'd4);
    chk("a_ready4", 32'(rdy[0]), 32'd1);
    addr[0] = 32'hBFC00004; #1;
    chk("a_fetch4", rd[0], 32'h0610A400);
    addr[0] = 32'hBFC00000; #1;
    chk("a_fetch0", rd[0], 32'h06608424);
    addr[0] = 32'hBFC00010; #1;
    chk("a_unloaded", rd[0], 32'h00000000);
    tick();
    chk("a_unloaded_nofault", 32'(flt[0]), 32'd0);
    addr[0] = 32'hBFBFFFFC; #1;
    chk("a_below_base", rd[0], 32'h00000000);
    addr[0] = 32'hBFC00000;

    // misaligned first fault is retained
    tick();
    addr[0] = 32'hBFC00002; #1;
    chk("a_misaligned_data", rd[0], 32'h00000000);
    tick();
    chk("a_fault1", 32'(flt[0]), 32'd1);
    chk("a_faddr1", fa[0], 32'hBFC00002);
    addr[0] = 32'hBFC00400;
    tick();
    chk("a_fault2", 32'(flt[0]), 32'd1);
    chk("a_faddr2", fa[0], 32'hBFC00002);
    addr[0] = 32'h0;

    // full array on a 4-word instance
    ce[1] = 1'b1;
    for (int i = 0; i < 4; i++) load(1, 32'hA0000000 + 32'(i));
    chk("b_ready_full", 32'(rdy[1]), 32'd0);
    chk("b_loaded_full", 32'(lw_b), 32'd4);
    load(1, 32'hA0000004);
    chk("b_loaded_ignored", 32'(lw_b), 32'd4);
    addr[1] = 32'hBFC0000C; #1;
    chk("b_fetch_last", rd[1], 32'hA0000003);
    addr[1] = 32'hBFC00010; #1;
    chk("b_fetch_oob", rd[1], 32'hDEADBEEF);
    tick();
    chk("b_fault", 32'(flt[1]), 32'd1);
    chk("b_faddr", fa[1], 32'hBFC00010);
    addr[1] = 32'h0;

    // registered read
    load(2, 32'h11223344);
    load(2, 32'h55667788);
    chk("c_valid_idle", 32'(vld[2]), 32'd0);
    chk("c_rdata_idle", rd[2], 32'h0);
    addr[2] = 32'hBFC00000;
    ce[2] = 1'b1; #1;
    chk("c_pre_edge", rd[2], 32'h0);
    tick();
    chk("c_rdata0", rd[2], 32'h44332211);
    chk("c_valid", 32'(vld[2]), 32'd1);
    ce[2] = 1'b0;
    addr[2] = 32'hBFC00004;
    tick();
    chk("c_hold", rd[2], 32'h44332211);
    chk("c_valid_hold", 32'(vld[2]), 32'd1);
    ce[2] = 1'b1;
    tick();
    chk("c_rdata1", rd[2], 32'h88776655);

    // reset in the middle of a load
    load(0, 32'h11111111);
    load(0, 32'h22222222);
    chk("a_loaded6", 32'(lw_a), 32'd6);
    reset = 1'b1; #2;
    chk("a_async_loaded", 32'(lw_a), 32'd0);
    chk("a_async_fault", 32'(flt[0]), 32'd0);
    chk("c_async_valid", 32'(vld[2]), 32'd0);
    reset = 1'b0;
    load(0, 32'h12345678);
    chk("a_loaded1", 32'(lw_a), 32'd1);
    addr[0] = 32'hBFC00004; #1;
    chk("a_stale_fill", rd[0], 32'h00000000);
    tick();
    chk("a_stale_nofault", 32'(flt[0]), 32'd0);
    addr[0] = 32'hBFC00000; #1;
    chk("a_reload0", rd[0], 32'h78563412);

    // clear beats a simultaneous load
    lc[0] = 1'b1;
    lv[0] = 1'b1;
    ld[0] = 32'h9999AAAA;
    tick();
    lc[0] = 1'b0;
    lv[0] = 1'b0;
    chk("a_clear_loaded", 32'(lw_a), 32'd0);
    addr[0] = 32'h0; #1;
    chk("a_halt_fill", rd[0], 32'h00000000);
    tick();
    chk("a_halt_nofault", 32'(flt[0]), 32'd0);
    load(0, 32'h0A0B0C0D);
    addr[0] = 32'hBFC00000; #1;
    chk("a_rewound", rd[0], 32'h0D0C0B0A);
    chk("a_rewound_cnt", 32'(lw_a), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
